// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//   Shared types for the accumulator stage built around the ripple-carry
//   adder/subtractor.
//   - op_e    : operation encoding carried on the 'op' input
//   - state_e : handshake FSM states of addsub_accumulator
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage : addsub_pkg

// File: rtl/addsub_flag_unit.sv
// -----------------------------------------------------------------------------
// addsub_flag_unit
//   Combinational next-state logic for the accumulator and its flags. It takes
//   the current accumulator, the captured operand and the adder result, and
//   produces the value to be loaded at the end of EXEC.
//   Optional macro ADDSUB_ACC_SATURATE_EN: on a signed overflow of ADD/SUB,
//   clamp the accumulator to the most positive or most negative value (chosen
//   by the sign of the accumulator). The V and C flags still report the raw
//   adder outcome.
//   Ports:
//     op       in  : captured operation (op_e)
//     a        in  : current accumulator (adder A input)
//     b        in  : captured operand (adder B input)
//     s, cout  in  : adder result
//     acc_next out : accumulator value to load
//     c_next, v_next, z_next, n_next out : flag values to load
// -----------------------------------------------------------------------------
module addsub_flag_unit
    import addsub_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  op_e             op,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [SIZE-1:0] s,
    input  logic            cout,
    output logic [SIZE-1:0] acc_next,
    output logic            c_next,
    output logic            v_next,
    output logic            z_next,
    output logic            n_next
);

    logic [SIZE-1:0] bc;
    logic            v_raw;

    // Signed overflow: both effective operands share a sign and the result
    // sign differs from it.
    assign bc    = b ^ {SIZE{op == OP_SUB}};
    assign v_raw = (a[SIZE-1] == bc[SIZE-1]) && (s[SIZE-1] != a[SIZE-1]);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        acc_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        unique case (op)
            OP_LOAD: begin
                acc_next = b;
            end
            OP_ADD, OP_SUB: begin
                acc_next = s;
                c_next   = cout;
                v_next   = v_raw;
`ifdef ADDSUB_ACC_SATURATE_EN
                if (v_raw) begin
                    acc_next = a[SIZE-1] ? {1'b1, {(SIZE-1){1'b0}}}
                                         : {1'b0, {(SIZE-1){1'b1}}};
                end
`endif
            end
            OP_CLEAR: begin
                acc_next = '0;
            end
            default: begin
                acc_next = '0;
            end
        endcase
    end

    assign z_next = (acc_next == '0);
    assign n_next = acc_next[SIZE-1];

endmodule : addsub_flag_unit

// File: rtl/ripple_carry_adder_subtractor.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder_subtractor
//   SIZE-bit ripple-carry adder/subtractor. With ctrl=0 it computes a + b.
//   With ctrl=1 it computes a - b as a + ~b + 1. For subtraction cout=1 means
//   no borrow.
//   Ports:
//     a, b  [SIZE-1:0] in  : operands
//     ctrl             in  : 0 add, 1 subtract
//     s     [SIZE-1:0] out : sum / difference (modulo 2^SIZE)
//     cout             out : carry out of the msb
// -----------------------------------------------------------------------------
module ripple_carry_adder_subtractor #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            ctrl,
    output logic [SIZE-1:0] s,
    output logic            cout
);

    logic [SIZE-1:0] bc;
    logic [SIZE:0]   carry;

    // Inverting b and injecting ctrl as carry-in turns the adder into a - b.
    assign bc       = b ^ {SIZE{ctrl}};
    assign carry[0] = ctrl;

    for (genvar i = 0; i < SIZE; i++) begin : g_bit
        assign s[i]       = a[i] ^ bc[i] ^ carry[i];
        assign carry[i+1] = (a[i] & bc[i]) | (carry[i] & (a[i] ^ bc[i]));
    end

    assign cout = carry[SIZE];

endmodule : ripple_carry_adder_subtractor

// File: rtl/addsub_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_accumulator
//   Accumulator stage around ripple_carry_adder_subtractor. It accepts one
//   op + operand per input handshake, executes for one cycle, then presents
//   acc and flags on the output handshake. Throughput is one op per 3 cycles.
//   Optional macro ADDSUB_ACC_SATURATE_EN: saturating ADD/SUB
//   (see addsub_flag_unit).
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     in_valid / in_ready : input handshake
//     op [1:0]            : 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//     operand [SIZE-1:0]  : operand for LOAD/ADD/SUB
//     out_valid/out_ready : output handshake
//     acc [SIZE-1:0]      : accumulator
//     flag_c/v/z/n        : carry (no-borrow on SUB), overflow, zero, negative
// -----------------------------------------------------------------------------
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [SIZE-1:0] operand,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] acc,
    output logic            flag_c,
    output logic            flag_v,
    output logic            flag_z,
    output logic            flag_n
);

    state_e          state, state_n;
    op_e             op_q;
    logic [SIZE-1:0] opnd_q;

    logic [SIZE-1:0] sum;
    logic            cout;
    logic [SIZE-1:0] acc_next;
    logic            c_next, v_next, z_next, n_next;

    // in_ready is gated by rst_n so it stays low for the whole reset window.
    assign in_ready  = (state == ST_IDLE) && rst_n;
    assign out_valid = (state == ST_RESP);

    ripple_carry_adder_subtractor #(.SIZE(SIZE)) u_addsub (
        .a    (acc),
        .b    (opnd_q),
        .ctrl (op_q == OP_SUB),
        .s    (sum),
        .cout (cout)
    );

    addsub_flag_unit #(.SIZE(SIZE)) u_flags (
        .op       (op_q),
        .a        (acc),
        .b        (opnd_q),
        .s        (sum),
        .cout     (cout),
        .acc_next (acc_next),
        .c_next   (c_next),
        .v_next   (v_next),
        .z_next   (z_next),
        .n_next   (n_next)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (in_valid)  state_n = ST_EXEC;
            ST_EXEC:                state_n = ST_RESP;
            ST_RESP: if (out_ready) state_n = ST_IDLE;
            default:                state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled
    // on the clock edge (synchronous), so it wins over any in-flight EXEC update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b1;
            flag_n <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_EXEC) begin
                acc    <= acc_next;
                flag_c <= c_next;
                flag_v <= v_next;
                flag_z <= z_next;
                flag_n <= n_next;
            end
        end
    end

    // NOTE: the captured op/operand are pure datapath and need no reset; they
    // are only consumed in EXEC, which is always preceded by a capture.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            op_q   <= op_e'(op);
            opnd_q <= operand;
        end
    end

endmodule : addsub_accumulator

// File: tb/tb_addsub_accumulator.sv
// -----------------------------------------------------------------------------
// tb_addsub_accumulator
//   Scoreboard bench for addsub_accumulator (SIZE=4). The expected acc/flags
//   are computed from integer arithmetic when an op is accepted and popped
//   when the DUT completes an output handshake.
// -----------------------------------------------------------------------------
module tb_addsub_accumulator;
    import addsub_pkg::*;

    localparam int SIZE = 4;
    localparam int SMAX = (1 << (SIZE - 1)) - 1;
    localparam int SMIN = -(1 << (SIZE - 1));

    typedef struct packed {
        logic [SIZE-1:0] acc;
        logic            c;
        logic            v;
        logic            z;
        logic            n;
    } res_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [SIZE-1:0] operand;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] acc;
    logic            flag_c, flag_v, flag_z, flag_n;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t model;

    addsub_accumulator #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t reset_state();
        res_t r;
        r.acc = '0; r.c = 1'b0; r.v = 1'b0; r.z = 1'b1; r.n = 1'b0;
        return r;
    endfunction

    // Reference built on integer arithmetic, not on the adder structure.
    function automatic res_t model_step(res_t cur, logic [1:0] o, logic [SIZE-1:0] b);
        res_t            nx;
        int              sa, sb, r;
        logic [SIZE:0]   wide;
        nx    = cur;
        sa    = $signed(cur.acc);
        sb    = $signed(b);
        nx.c  = 1'b0;
        nx.v  = 1'b0;
        case (o)
            OP_LOAD:  nx.acc = b;
            OP_ADD: begin
                wide   = {1'b0, cur.acc} + {1'b0, b};
                nx.acc = wide[SIZE-1:0];
                nx.c   = wide[SIZE];
                r      = sa + sb;
                nx.v   = (r > SMAX) || (r < SMIN);
            end
            OP_SUB: begin
                nx.acc = cur.acc - b;
                nx.c   = (cur.acc >= b);
                r      = sa - sb;
                nx.v   = (r > SMAX) || (r < SMIN);
            end
            default:  nx.acc = '0;
        endcase
`ifdef ADDSUB_ACC_SATURATE_EN
        if ((o == OP_ADD || o == OP_SUB) && nx.v)
            nx.acc = cur.acc[SIZE-1] ? SIZE'(1 << (SIZE - 1)) : SIZE'(SMAX);
`endif
        nx.z = (nx.acc == '0);
        nx.n = nx.acc[SIZE-1];
        return nx;
    endfunction

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("acc",    32'(acc),    32'(e.acc));
                check("flag_c", 32'(flag_c), 32'(e.c));
                check("flag_v", 32'(flag_v), 32'(e.v));
                check("flag_z", 32'(flag_z), 32'(e.z));
                check("flag_n", 32'(flag_n), 32'(e.n));
            end
        end
    end

    // Offer one op; called #1 after a posedge, returns #1 after the accepting edge.
    task automatic send_op(input logic [1:0] o, input logic [SIZE-1:0] b);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        op       = o;
        operand  = b;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            model = model_step(model, o, b);
            exp_q.push_back(model);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int pulses;
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        operand   = '0;
        out_ready = 1'b1;
        model     = reset_state();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acc",       32'(acc),       32'd0);
        check("rst_flag_c",    32'(flag_c),    32'd0);
        check("rst_flag_v",    32'(flag_v),    32'd0);
        check("rst_flag_z",    32'(flag_z),    32'd1);
        check("rst_flag_n",    32'(flag_n),    32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // LOAD 5, ADD 3 (overflow); LOAD 3, SUB 5 (borrow); LOAD 7, ADD 9, CLEAR
        send_op(OP_LOAD, 4'd5);  wait_drain();
        send_op(OP_ADD,  4'd3);  wait_drain();
        send_op(OP_LOAD, 4'd3);  wait_drain();
        send_op(OP_SUB,  4'd5);  wait_drain();
        send_op(OP_LOAD, 4'd7);  wait_drain();
        send_op(OP_ADD,  4'd9);  wait_drain();
        send_op(OP_CLEAR, 4'd6); wait_drain();

        // Backpressure: LOAD 2 held in RESP for 5 cycles, extra offer ignored
        out_ready = 1'b0;
        send_op(OP_LOAD, 4'd2);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("bp_out_valid_seen", 32'(seen), 32'd1);
        in_valid = 1'b1;
        op       = OP_ADD;
        operand  = 4'd7;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_acc",       32'(acc),       32'd2);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_queue_empty",    32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Reset asserted during EXEC of ADD 1 after LOAD 9
        send_op(OP_LOAD, 4'd9); wait_drain();
        in_valid = 1'b1;
        op       = OP_ADD;
        operand  = 4'd1;
        @(negedge clk);
        check("mid_rst_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_in_exec", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        model = reset_state();
        @(negedge clk);
        check("mid_rst_acc",       32'(acc),       32'd0);
        check("mid_rst_flag_z",    32'(flag_z),    32'd1);
        check("mid_rst_flag_n",    32'(flag_n),    32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mid_rst_no_pulse", 32'(pulses), 32'd0);
        @(posedge clk); #1;

        // Mixed sequence with edge operands
        send_op(OP_SUB,  4'd0);  wait_drain();
        send_op(OP_SUB,  4'd8);  wait_drain();
        send_op(OP_LOAD, 4'd8);  wait_drain();
        send_op(OP_SUB,  4'd1);  wait_drain();
        send_op(OP_ADD,  4'd15); wait_drain();
        for (int i = 0; i < 12; i++) begin
            send_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            wait_drain();
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_addsub_accumulator
